rf_read_arbiter: RTL

- Round-robin arbiter and sequencer that shares one 32-bit 32x1 register-file read mux between several requesters.
- Example requesters: fetch/decode operand reads and debug/test ports.
- Per transaction: grants one requester, drives the mux select, allows one settle cycle for the gate-level mux tree, captures the data, and returns it with a one-cycle acknowledge.
- Sits between the register file storage/mux and the control unit.

---
 rtl/rf_read_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter/sequencer sharing one register-file read mux (IDLE -> SEL -> CAPT).
// Optional macro RF_ARB_R0_BYPASS_EN: reads of address 0 complete at the grant edge with zero data.
module rf_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_REQ-1:0]        REQ,
  input  logic [NUM_REQ*ADDR_W-1:0] ADDR,
  output logic [ADDR_W-1:0]         MUX_SEL,
  input  logic [DATA_W-1:0]         MUX_Y,
  output logic [DATA_W-1:0]         DATA_OUT,
  output logic [NUM_REQ-1:0]        ACK,
  output logic                      BUSY
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SEL, CAPT} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_gnt;
  logic [ADDR_W-1:0]  r_mux_sel;
  logic [DATA_W-1:0]  r_data;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_busy;

  logic [NUM_REQ-1:0] w_elig;
  logic               w_found;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic [ADDR_W-1:0]  w_gnt_addr;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_REQ-1)) ? '0 : idx + 1'b1;
  endfunction

  // A requester acked this cycle still holds REQ high; mask it so it is not re-granted.
  always_comb begin
    int j;
    j         = 0;
    w_elig    = REQ & ~r_ack;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(r_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!w_found && w_elig[IDX_W'(j)]) begin
        w_found   = 1'b1;
        w_gnt_idx = IDX_W'(j);
      end
    end
    w_gnt_addr = ADDR[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_mux_sel <= '0;
      r_data    <= '0;
      r_ack     <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
`ifdef RF_ARB_R0_BYPASS_EN
            if (w_gnt_addr == '0) begin
              r_data <= '0;
              r_ack  <= onehot(w_gnt_idx);
              r_ptr  <= next_ptr(w_gnt_idx);
            end else
`endif
            begin
              r_gnt     <= w_gnt_idx;
              r_mux_sel <= w_gnt_addr;
              r_busy    <= 1'b1;
              r_state   <= SEL;
            end
          end
        end
        // Settle cycle: the gate-level mux tree needs one full cycle after MUX_SEL moves.
        SEL: r_state <= CAPT;
        CAPT: begin
          r_data  <= MUX_Y;
          r_ack   <= onehot(r_gnt);
          r_ptr   <= next_ptr(r_gnt);
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign MUX_SEL  = r_mux_sel;
  assign DATA_OUT = r_data;
  assign ACK      = r_ack;
  assign BUSY     = r_busy;

endmodule
